// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths, bank encodings and reset defaults for the core state unit
package core_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic        BANK_INT         = 1'b0;
  localparam logic        BANK_FP          = 1'b1;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

endpackage

// File: rtl/core_state_unit_if.sv
// rtl/core_state_unit_if.sv - front-end/back-end bus into the core state unit
interface core_state_unit_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 1
) ();
  localparam int IDXW = $clog2(NREG);

  logic                 stall;
  logic                 pred_valid;
  logic [XLEN-1:0]      pred_pc;
  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_pc;
  logic [XLEN-1:0]      pc;
  logic [NRD-1:0]       rd_bank;
  logic [NRD*IDXW-1:0]  rd_idx;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR-1:0]       wr_bank;
  logic [NWR*IDXW-1:0]  wr_idx;
  logic [NWR*XLEN-1:0]  wr_data;
  logic                 claim_en;
  logic                 claim_bank;
  logic [IDXW-1:0]      claim_idx;
  logic                 flush;

  modport master (
    output stall, pred_valid, pred_pc, redirect_valid, redirect_pc,
    output rd_bank, rd_idx, wr_en, wr_bank, wr_idx, wr_data,
    output claim_en, claim_bank, claim_idx, flush,
    input  pc, rd_data, rd_busy
  );

  modport slave (
    input  stall, pred_valid, pred_pc, redirect_valid, redirect_pc,
    input  rd_bank, rd_idx, wr_en, wr_bank, wr_idx, wr_data,
    input  claim_en, claim_bank, claim_idx, flush,
    output pc, rd_data, rd_busy
  );

endinterface

// File: rtl/core_state_unit_regbank.sv
// rtl/core_state_unit_regbank.sv - one NREG x XLEN register bank, NRD reads, NWR writes, optional hardwired r0
module core_state_unit_regbank #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 1,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0,
  localparam int IDXW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRD*IDXW-1:0] rd_idx,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*IDXW-1:0] wr_idx,
  input  logic [NWR*XLEN-1:0] wr_data
);

  logic [XLEN-1:0] mem [NREG];

  function automatic logic wr_live(input int j);
    return wr_en[j] && !(ZERO_R0 && (wr_idx[j*IDXW +: IDXW] == '0));
  endfunction

  // Ascending port order lets the highest-numbered writer win.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_live(j)) mem[wr_idx[j*IDXW +: IDXW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [IDXW-1:0] idx);
    logic [XLEN-1:0] val;
    val = mem[idx];
    if (BYPASS) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_live(j) && (wr_idx[j*IDXW +: IDXW] == idx)) val = wr_data[j*XLEN +: XLEN];
      end
    end
    if (ZERO_R0 && (idx == '0)) val = '0;
    return val;
  endfunction

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_data[k*XLEN +: XLEN] = read_port(rd_idx[k*IDXW +: IDXW]);
    end
  end

endmodule

// File: rtl/core_state_unit.sv
// rtl/core_state_unit.sv - program counter, int/fp register banks and busy scoreboard
module core_state_unit
  import core_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              NREG     = 32,
  parameter int              NRD      = 2,
  parameter int              NWR      = 1,
  parameter bit              BYPASS   = 1'b1,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT[XLEN-1:0],
  localparam int             IDXW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rstn,
  core_state_unit_if.slave  bus
);

  logic [XLEN-1:0]     pc_q;
  logic [NWR-1:0]      wr_en_int, wr_en_fp;
  logic [NRD*XLEN-1:0] int_rd, fp_rd;
  logic [NREG-1:0]     busy_int, busy_fp, busy_int_n, busy_fp_n;

  // Redirect outranks stall so a mispredict is never lost behind a held front end.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                pc_q <= RESET_PC;
    else if (bus.redirect_valid)              pc_q <= bus.redirect_pc;
    else if (!bus.stall && bus.pred_valid)    pc_q <= bus.pred_pc;
  end
  assign bus.pc = pc_q;

  always_comb begin
    wr_en_int = '0;
    wr_en_fp  = '0;
    for (int j = 0; j < NWR; j++) begin
      wr_en_int[j] = bus.wr_en[j] && (bus.wr_bank[j] == BANK_INT);
      wr_en_fp[j]  = bus.wr_en[j] && (bus.wr_bank[j] == BANK_FP);
    end
  end

  core_state_unit_regbank #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(BYPASS), .ZERO_R0(1'b1)
  ) u_int_bank (
    .clk(clk), .rstn(rstn), .rd_idx(bus.rd_idx), .rd_data(int_rd),
    .wr_en(wr_en_int), .wr_idx(bus.wr_idx), .wr_data(bus.wr_data)
  );

  core_state_unit_regbank #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(BYPASS), .ZERO_R0(1'b0)
  ) u_fp_bank (
    .clk(clk), .rstn(rstn), .rd_idx(bus.rd_idx), .rd_data(fp_rd),
    .wr_en(wr_en_fp), .wr_idx(bus.wr_idx), .wr_data(bus.wr_data)
  );

  // Clear on writeback first, then set on claim, so a same-cycle claim marks the new producer.
  always_comb begin
    busy_int_n = busy_int;
    busy_fp_n  = busy_fp;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en_int[j]) busy_int_n[bus.wr_idx[j*IDXW +: IDXW]] = 1'b0;
      if (wr_en_fp[j])  busy_fp_n[bus.wr_idx[j*IDXW +: IDXW]]  = 1'b0;
    end
    if (bus.claim_en) begin
      if (bus.claim_bank == BANK_FP)  busy_fp_n[bus.claim_idx]  = 1'b1;
      else if (bus.claim_idx != '0)   busy_int_n[bus.claim_idx] = 1'b1;
    end
    if (bus.flush) begin
      busy_int_n = '0;
      busy_fp_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_int <= '0;
      busy_fp  <= '0;
    end else begin
      busy_int <= busy_int_n;
      busy_fp  <= busy_fp_n;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      bus.rd_data[k*XLEN +: XLEN] = bus.rd_bank[k] ? fp_rd[k*XLEN +: XLEN] : int_rd[k*XLEN +: XLEN];
      bus.rd_busy[k] = bus.rd_bank[k] ? busy_fp[bus.rd_idx[k*IDXW +: IDXW]]
                                      : busy_int[bus.rd_idx[k*IDXW +: IDXW]];
    end
  end

endmodule
